// File: rtl/sha256_params_pkg.sv
// Shared constants for the SHA-256 message padder: state encodings, block geometry
// and the padding marker byte.
package sha256_params_pkg;

    localparam int BLOCK_NO = 16;
    localparam logic [7:0] PAD_BYTE = 8'h80;

    typedef logic [1:0] state_t;
    localparam state_t ST_FILL    = 2'd0;
    localparam state_t ST_PAD     = 2'd1;
    localparam state_t ST_LEN_BLK = 2'd2;
    localparam state_t ST_EMIT    = 2'd3;

    // Which extra block, if any, must follow the one currently being emitted.
    typedef logic [1:0] pend_t;
    localparam pend_t PEND_NONE = 2'd0;
    localparam pend_t PEND_PAD  = 2'd1;
    localparam pend_t PEND_LEN  = 2'd2;

    function automatic logic [31:0] byte_mask(input logic [2:0] nb);
        case (nb)
            3'd0:    byte_mask = 32'h0000_0000;
            3'd1:    byte_mask = 32'hFF00_0000;
            3'd2:    byte_mask = 32'hFFFF_0000;
            3'd3:    byte_mask = 32'hFFFF_FF00;
            default: byte_mask = 32'hFFFF_FFFF;
        endcase
    endfunction

endpackage

// File: rtl/sha256_msg_pad.sv
// SHA-256 message padder: packs 32-bit words into 512-bit blocks, appends the
// 0x80 marker and the 64-bit bit length, and hands blocks to the hash core.
//
// state    | meaning
// FILL     | accepting message words into the block buffer
// PAD      | building a block of 0x80 marker + zeros + length
// LEN_BLK  | building a block of zeros + length
// EMIT     | block presented on blk_data until the consumer takes it
module sha256_msg_pad
    import sha256_params_pkg::*;
#(
    parameter int DATA_WIDTH  = 32,
    parameter int BLOCK_WIDTH = 512
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic                   zeroize,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [DATA_WIDTH-1:0]  in_data,
    input  logic [2:0]             in_bytes,
    input  logic                   in_last,
    output logic                   blk_valid,
    input  logic                   blk_ready,
    output logic [BLOCK_WIDTH-1:0] blk_data,
    output logic                   blk_first,
    output logic                   blk_last,
    output logic                   busy,
    output logic                   proto_err
);

    state_t      state_q;
    pend_t       pend_q;
    logic [3:0]  widx_q;
    logic [63:0] cnt_q;
    logic [31:0] blk_buf_q [BLOCK_NO];
    logic        blk_first_q;
    logic        blk_last_q;
    logic        proto_err_q;

    logic        accept;
    logic        bad_word;
    logic [31:0] masked;
    logic [31:0] pad_word;
    logic [63:0] cnt_add;
    logic [6:0]  n_bytes;
    logic        short_msg;
    logic        full_blk;
    logic [31:0] fin_blk [BLOCK_NO];

    assign accept    = in_valid && (state_q == ST_FILL);
    assign bad_word  = ((in_bytes == 3'd0) && !in_last) || (in_bytes > 3'd4);
    assign masked    = in_data & byte_mask(in_bytes);
    assign pad_word  = (in_bytes < 3'd4) ? ({PAD_BYTE, 24'h0} >> {in_bytes[1:0], 3'b000}) : 32'h0;
    assign cnt_add   = cnt_q + {58'h0, in_bytes, 3'b000};
    assign n_bytes   = {1'b0, widx_q, 2'b00} + {4'h0, in_bytes};
    assign short_msg = (n_bytes <= 7'd55);
    assign full_blk  = (n_bytes == 7'd64);

    // Final data block: keep earlier words, merge the marker, zero everything above.
    always_comb begin
        for (int i = 0; i < BLOCK_NO; i++) begin
            fin_blk[i] = 32'h0;
            if (4'(i) < widx_q) begin
                fin_blk[i] = blk_buf_q[i];
            end else if (4'(i) == widx_q) begin
                fin_blk[i] = masked | pad_word;
            end else if ((5'(i) == ({1'b0, widx_q} + 5'd1)) && (in_bytes == 3'd4)) begin
                fin_blk[i] = {PAD_BYTE, 24'h0};
            end
        end
        if (short_msg) begin
            fin_blk[14] = cnt_add[63:32];
            fin_blk[15] = cnt_add[31:0];
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= ST_FILL;
            pend_q      <= PEND_NONE;
            widx_q      <= 4'd0;
            cnt_q       <= 64'h0;
            blk_first_q <= 1'b1;
            blk_last_q  <= 1'b0;
            proto_err_q <= 1'b0;
            for (int i = 0; i < BLOCK_NO; i++) blk_buf_q[i] <= 32'h0;
        end else if (zeroize) begin
            state_q     <= ST_FILL;
            pend_q      <= PEND_NONE;
            widx_q      <= 4'd0;
            cnt_q       <= 64'h0;
            blk_first_q <= 1'b1;
            blk_last_q  <= 1'b0;
            proto_err_q <= 1'b0;
            for (int i = 0; i < BLOCK_NO; i++) blk_buf_q[i] <= 32'h0;
        end else begin
            case (state_q)
                ST_FILL: begin
                    if (accept) begin
                        if (bad_word) begin
                            proto_err_q <= 1'b1;
                        end else if (in_last) begin
                            for (int i = 0; i < BLOCK_NO; i++) blk_buf_q[i] <= fin_blk[i];
                            cnt_q      <= cnt_add;
                            widx_q     <= 4'd0;
                            state_q    <= ST_EMIT;
                            blk_last_q <= short_msg;
                            pend_q     <= short_msg ? PEND_NONE : (full_blk ? PEND_PAD : PEND_LEN);
                        end else begin
                            blk_buf_q[widx_q] <= masked;
                            cnt_q             <= cnt_add;
                            widx_q            <= widx_q + 4'd1;
                            if (widx_q == 4'd15) begin
                                state_q    <= ST_EMIT;
                                blk_last_q <= 1'b0;
                                pend_q     <= PEND_NONE;
                            end
                        end
                    end
                end
                ST_PAD, ST_LEN_BLK: begin
                    for (int i = 0; i < BLOCK_NO; i++) blk_buf_q[i] <= 32'h0;
                    if (state_q == ST_PAD) blk_buf_q[0] <= {PAD_BYTE, 24'h0};
                    blk_buf_q[14] <= cnt_q[63:32];
                    blk_buf_q[15] <= cnt_q[31:0];
                    blk_last_q    <= 1'b1;
                    state_q       <= ST_EMIT;
                end
                default: begin
                    if (blk_ready) begin
                        case (pend_q)
                            PEND_PAD: state_q <= ST_PAD;
                            PEND_LEN: state_q <= ST_LEN_BLK;
                            default:  state_q <= ST_FILL;
                        endcase
                        pend_q <= PEND_NONE;
                        if (blk_last_q) begin
                            cnt_q       <= 64'h0;
                            blk_first_q <= 1'b1;
                        end else begin
                            blk_first_q <= 1'b0;
                        end
                    end
                end
            endcase
        end
    end

    always_comb begin
        blk_data = '0;
        for (int i = 0; i < BLOCK_NO; i++) begin
            blk_data[BLOCK_WIDTH-1-32*i -: 32] = blk_buf_q[i];
        end
    end

    assign in_ready  = (state_q == ST_FILL);
    assign blk_valid = (state_q == ST_EMIT);
    assign blk_first = blk_first_q;
    assign blk_last  = blk_last_q;
    assign proto_err = proto_err_q;
    assign busy      = (widx_q != 4'd0) || (cnt_q != 64'h0) || (state_q != ST_FILL);

endmodule

// File: doc/sha256_msg_pad.md
SHA256_MSG_PAD -- requirements
Module: sha256_msg_pad

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, input word width; only 32 is supported.
REQ-002 SHALL have parameter BLOCK_WIDTH, default 512, output block width; fixed at 512.
REQ-003 SHALL have one clock and an asynchronous active-low reset, with ports as follows:
- clk  in  1  clock.
- reset_n  in  1  asynchronous active-low reset.
- zeroize  in  1  synchronous clear of all state and data.
- in_valid  in  1  input word valid.
- in_ready  out  1  input word accepted when in_valid&in_ready.
- in_data  in  32  message word, big-endian; byte 0 in [31:24].
- in_bytes  in  3  valid bytes in in_data, left-justified; 1..4, or 0 only with in_last.
- in_last  in  1  final word of message.
- blk_valid  out  1  padded block available.
- blk_ready  in  1  consumer accepts block when blk_valid&blk_ready.
- blk_data  out  512  block, word 0 in [511:480].
- blk_first  out  1  first block of message (core init); 0 = core next.
- blk_last  out  1  final block of message.
- busy  out  1  message in progress or block pending.
- proto_err  out  1  sticky protocol-error flag, cleared by reset or zeroize.

Function
REQ-004 SHALL implement states FILL, PAD, LEN_BLK and EMIT; reset state is FILL.
REQ-005 FILL: in_ready=1; each accepted word is stored at word index widx (0..15), widx increments, and the 64-bit bit counter adds 8*in_bytes (wraps mod 2^64).
REQ-006 In FILL, widx=15 accepted with in_last=0 SHALL go to EMIT with blk_last=0; widx wraps to 0.
REQ-007 In FILL, accepted in_last with total block bytes n=4*widx+in_bytes SHALL place 0x80 at byte n and zero all bytes above it.
- If n<=55: write the 64-bit length into words 14..15 and go to EMIT with blk_last=1.
- If 56<=n<=63: go to EMIT with blk_last=0, then to LEN_BLK.
- If n=64 (widx=15, in_bytes=4): go to EMIT with blk_last=0, then to PAD.
REQ-008 PAD SHALL build a block with word0=0x80000000, zeros, and the length in words 14..15, then go to EMIT with blk_last=1.
REQ-009 LEN_BLK SHALL build an all-zero block with the length in words 14..15, then go to EMIT with blk_last=1.
REQ-010 EMIT SHALL behave as follows:
- Drive blk_valid=1, with blk_data/blk_first/blk_last stable until accepted; in_ready=0.
- On acceptance: go to PAD/LEN_BLK if pending, else to FILL.
- If the accepted block had blk_last=1: clear the bit counter and set blk_first=1 for the next block.
REQ-011 blk_first SHALL be 1 only on the first block emitted after reset, zeroize or a completed message.
REQ-012 blk_valid SHALL assert the cycle after the completing word is accepted (1-cycle latency); PAD and LEN_BLK each take exactly one cycle.
REQ-013 Words accepted with in_bytes=0 and in_last=0, or with in_bytes>4, SHALL set proto_err and be dropped without changing the counter or widx.
REQ-014 in_last with in_bytes=0 at widx=0 and a zero counter (empty message) SHALL produce one block: 0x80000000, zeros, length 0.
REQ-015 busy SHALL be 1 whenever widx!=0, the counter is nonzero, or state!=FILL.
REQ-016 zeroize SHALL take priority over all handshakes in the same cycle: return to FILL, clear buffer, counter, widx and proto_err, and set blk_valid=0.

Reset
REQ-017 Reset SHALL set: state=FILL, widx=0, counter=0, buffer=0, blk_valid=0, blk_first=1, blk_last=0, in_ready=1, busy=0, proto_err=0.
REQ-018 Reset asserted mid-message or mid-EMIT SHALL abandon the message; no partial block is emitted afterwards.

Structure
REQ-019 The state enum, BLOCK_NO=16 and the 0x80 pad constant SHALL live in sha256_params_pkg.
REQ-020 SHALL be a single module with no sub-modules; it drives the SHA-256 top-level block/init/next registers directly.

Verification
REQ-021 "abc": in_data=0x61626300, in_bytes=3, in_last=1 -> one block: word0=0x61626380, words1..14=0, word15=0x00000018, first=last=1.
REQ-022 55-byte message -> one block, byte55=0x80, length=0x1B8; 56-byte message -> two blocks, the second all zero except word15=0x000001C0.
REQ-023 64-byte message -> two blocks: the first is the data (first=1, last=0); the second has word0=0x80000000 and word15=0x00000200 (last=1).
REQ-024 Empty message (in_bytes=0, in_last=1) -> one block: 0x80000000, zeros, length 0.
REQ-025 Hold blk_ready=0 for 10 cycles -> blk_data stable, in_ready=0, no words accepted; then two back-to-back messages -> blk_first reasserts on the second.
REQ-026 Zeroize asserted at widx=7 -> busy=0 next cycle, no block emitted; a following "abc" message matches REQ-021.
